// File: rtl/art_pkg.sv
// Shared definitions for the block-texture art path: texture geometry,
// pixel and slot types, block ids and the loader state encoding.
package art_pkg;

    localparam int TEX_W   = 40;
    localparam int TEX_H   = 40;
    localparam int TEX_PIX = TEX_W * TEX_H;

    typedef logic [23:0] rgb_t;
    typedef logic [3:0]  tex_id_t;

    typedef enum logic [3:0] {
        AIR      = 4'd0,
        BEDROCK  = 4'd1,
        WOOD     = 4'd2,
        STONE    = 4'd3,
        DIRT     = 4'd4,
        GRASS    = 4'd5,
        SAND     = 4'd6,
        GRAVEL   = 4'd7,
        COBBLE   = 4'd8,
        LEAVES   = 4'd9,
        GLASS    = 4'd10,
        BRICK    = 4'd11,
        COAL_ORE = 4'd12,
        IRON_ORE = 4'd13,
        GOLD_ORE = 4'd14,
        PLANKS   = 4'd15
    } block_id_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2
    } loader_state_e;

endpackage

// File: rtl/byte_to_rgb.sv
// Three-phase byte assembler: collects R, G, B bytes and flags the cycle in
// which the B byte is taken, presenting the complete {R,G,B} word alongside.
module byte_to_rgb
    import art_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       take,
    input  logic [7:0] in_byte,
    output logic       pix_valid,
    output rgb_t       pix
);

    logic [1:0] phase;
    logic [7:0] r;
    logic [7:0] g;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 2'd0;
        end else if (clr) begin
            phase <= 2'd0;
        end else if (take) begin
            phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (take && phase == 2'd0) r <= in_byte;
        if (take && phase == 2'd1) g <= in_byte;
    end

    assign pix_valid = take && (phase == 2'd2);
    assign pix       = {r, g, in_byte};

endmodule

// File: rtl/texture_loader.sv
// Texture RAM writer: parses a one-byte header, streams 1600 RGB888 pixels
// into the selected slot and tracks which slots hold a complete image.
module texture_loader
    import art_pkg::*;
#(
    parameter int         TEX_PIX   = art_pkg::TEX_PIX,
    parameter int         ADDR_W    = 11,
    parameter logic [3:0] HDR_MAGIC = 4'hA
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [3:0]        wr_id,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              hdr_err,
    output logic [15:0]       tex_loaded
);

    loader_state_e     state;
    loader_state_e     state_nxt;
    logic              ready_q;
    logic              accept;
    logic              hdr_ok;
    logic              hdr_take;
    logic              data_take;
    logic              pix_valid;
    logic              last_pix;
    rgb_t              pix;
    logic [ADDR_W-1:0] pix_cnt;

    // abort must block acceptance in the same cycle, so it bypasses the register
    assign in_ready  = ready_q & ~abort;
    assign accept    = in_valid & in_ready;
    assign hdr_ok    = (in_data[7:4] == HDR_MAGIC);
    assign hdr_take  = accept && (state == IDLE) && hdr_ok;
    assign data_take = accept && (state == DATA);
    assign last_pix  = pix_valid && (pix_cnt == ADDR_W'(TEX_PIX - 1));

    byte_to_rgb u_asm (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .clr       (abort | hdr_take),
        .take      (data_take),
        .in_byte   (in_data),
        .pix_valid (pix_valid),
        .pix       (pix)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (hdr_take) state_nxt = DATA;
                DATA:    if (last_pix) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ready_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hdr_err    <= 1'b0;
            wr_en      <= 1'b0;
            wr_id      <= 4'd0;
            wr_addr    <= '0;
            wr_data    <= 24'd0;
            pix_cnt    <= '0;
            tex_loaded <= 16'h0000;
        end else begin
            ready_q <= (state_nxt != DONE);
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == DONE);
            hdr_err <= accept && (state == IDLE) && !hdr_ok;
            wr_en   <= pix_valid;
            if (pix_valid) begin
                wr_addr <= pix_cnt;
                wr_data <= pix;
                if (!last_pix) pix_cnt <= pix_cnt + 1'b1;
            end
            if (hdr_take) begin
                wr_id                  <= in_data[3:0];
                tex_loaded[in_data[3:0]] <= 1'b0;
                pix_cnt                <= '0;
            end
            if (state == DONE && !abort) tex_loaded[wr_id] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_texture_loader.sv
// Bench for texture_loader: byte-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_texture_loader;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [3:0]  wr_id;
    logic [10:0] wr_addr;
    logic [23:0] wr_data;
    logic        busy;
    logic        done;
    logic        hdr_err;
    logic [15:0] tex_loaded;

    texture_loader dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_id      (wr_id),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .hdr_err    (hdr_err),
        .tex_loaded (tex_loaded)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: predicted outputs after the coming edge
    bit          e_ready, e_wr_en, e_busy, e_done, e_herr;
    logic [10:0] e_addr;
    logic [23:0] e_data;
    logic [3:0]  e_id;
    logic [15:0] m_loaded;
    bit          m_recv, m_fin;
    logic [7:0]  m_bytes[$];
    int          m_npix;

    int          wr_cnt = 0, herr_cnt = 0, done_cyc = 0, hdr_cyc = 0;
    logic [10:0] last_wr_addr = '0;
    logic [23:0] addr0_data = '0;

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    initial forever begin
        @(negedge Clk);
        if (!Reset_n) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_wr_en", 32'(wr_en), 32'd0);
            chk("rst_wr_addr", 32'(wr_addr), 32'd0);
            chk("rst_wr_data", 32'(wr_data), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_loaded", 32'(tex_loaded), 32'd0);
            e_ready = 1; e_wr_en = 0; e_busy = 0; e_done = 0; e_herr = 0;
            e_addr = '0; e_data = '0; e_id = '0; m_loaded = '0;
            m_recv = 0; m_fin = 0; m_npix = 0; m_bytes.delete();
        end else begin
            chk("in_ready", 32'(in_ready), 32'(e_ready && !abort));
            chk("wr_en", 32'(wr_en), 32'(e_wr_en));
            chk("wr_addr", 32'(wr_addr), 32'(e_addr));
            chk("wr_data", 32'(wr_data), 32'(e_data));
            chk("wr_id", 32'(wr_id), 32'(e_id));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("hdr_err", 32'(hdr_err), 32'(e_herr));
            chk("tex_loaded", 32'(tex_loaded), 32'(m_loaded));
            if (wr_en) begin
                wr_cnt++;
                last_wr_addr = wr_addr;
                if (wr_addr == 11'd0) addr0_data = wr_data;
            end
            if (hdr_err) herr_cnt++;
            if (done) done_cyc = cyc;

            e_wr_en = 0; e_done = 0; e_herr = 0;
            if (abort) begin
                m_recv = 0; m_fin = 0; m_bytes.delete();
            end else if (m_fin) begin
                m_loaded[e_id] = 1'b1;
                m_fin = 0;
            end else if (in_valid && e_ready) begin
                if (!m_recv) begin
                    if (in_data[7:4] == 4'hA) begin
                        m_recv = 1; e_id = in_data[3:0]; m_loaded[in_data[3:0]] = 1'b0;
                        m_npix = 0; m_bytes.delete(); hdr_cyc = cyc + 1;
                    end else begin
                        e_herr = 1;
                    end
                end else begin
                    m_bytes.push_back(in_data);
                    if (m_bytes.size() == 3) begin
                        e_wr_en = 1;
                        e_addr  = 11'(m_npix);
                        e_data  = {m_bytes[0], m_bytes[1], m_bytes[2]};
                        m_bytes.delete();
                        m_npix++;
                        if (m_npix == 1600) begin
                            m_recv = 0; m_fin = 1; e_done = 1;
                        end
                    end
                end
            end
            e_busy  = m_recv || m_fin;
            e_ready = !m_fin;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the byte was taken
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        int n;
        if (gap > 0 && $urandom_range(99) < gap) begin
            repeat ($urandom_range(3, 1)) begin
                @(posedge Clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        got = 0;
        n = 0;
        while (!got && n < 50) begin
            @(negedge Clk);
            got = in_ready;
            @(posedge Clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("byte_accepted", 32'(got), 32'd1);
    endtask

    task automatic send_tex(input logic [3:0] id, input int gap, input bit pat);
        send_byte({4'hA, id}, gap);
        for (int n = 0; n < 1600; n++) begin
            if (pat) begin
                send_byte(8'(n), gap);
                send_byte(8'h55, gap);
                send_byte(8'hAA, gap);
            end else begin
                repeat (3) send_byte(8'($urandom), gap);
            end
        end
    endtask

    task automatic pulse_abort();
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1;
        chk("abort_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge Clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    int w0, h0;

    initial begin
        @(negedge Clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_loaded", 32'(tex_loaded), 32'h0);
        @(negedge Clk);
        #1 Reset_n = 1'b1;
        settle(1);

        // full texture, slot 3, pattern pixels, no gaps
        w0 = wr_cnt;
        send_tex(4'd3, 0, 1'b1);
        settle(3);
        chk("t1_write_count", 32'(wr_cnt - w0), 32'd1600);
        chk("t1_pix0_data", 32'(addr0_data), 32'h0055AA);
        chk("t1_last_addr", 32'(last_wr_addr), 32'd1599);
        chk("t1_done_latency", 32'(done_cyc - hdr_cyc), 32'd4800);
        chk("t1_loaded", 32'(tex_loaded), 32'h0008);

        // bad header, then slot 12
        h0 = herr_cnt;
        w0 = wr_cnt;
        send_byte(8'h5C, 0);
        chk("t2_hdr_err_pulse", 32'(hdr_err), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        settle(2);
        chk("t2_hdr_err_count", 32'(herr_cnt - h0), 32'd1);
        chk("t2_no_write", 32'(wr_cnt - w0), 32'd0);
        send_tex(4'd12, 0, 1'b0);
        settle(3);
        chk("t2_loaded", 32'(tex_loaded), 32'h1008);

        // slot 7 with random idle gaps
        w0 = wr_cnt;
        send_tex(4'd7, 30, 1'b0);
        settle(3);
        chk("t3_write_count", 32'(wr_cnt - w0), 32'd1600);
        chk("t3_last_addr", 32'(last_wr_addr), 32'd1599);
        chk("t3_loaded", 32'(tex_loaded), 32'h1088);

        // abort after two bytes of pixel 10
        w0 = wr_cnt;
        send_byte(8'hA6, 0);
        repeat (32) send_byte(8'($urandom), 0);
        pulse_abort();
        settle(2);
        chk("t4_write_count", 32'(wr_cnt - w0), 32'd10);
        chk("t4_last_addr", 32'(last_wr_addr), 32'd9);
        chk("t4_loaded", 32'(tex_loaded), 32'h1088);
        chk("t4_ready_idle", 32'(in_ready), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        send_byte(8'hA6, 0);
        repeat (9) send_byte(8'($urandom), 0);
        settle(2);
        chk("t4_restart_count", 32'(wr_cnt - w0), 32'd13);
        chk("t4_restart_addr", 32'(last_wr_addr), 32'd2);
        pulse_abort();

        // reload of a loaded slot clears its bit at the header
        send_tex(4'd2, 0, 1'b0);
        settle(3);
        chk("t5_loaded_set", 32'(tex_loaded), 32'h108C);
        send_byte(8'hA2, 0);
        chk("t5_loaded_clear", 32'(tex_loaded), 32'h1088);
        repeat (100) send_byte(8'($urandom), 0);
        pulse_abort();
        settle(2);

        // asynchronous reset in the middle of a transfer
        send_byte(8'hA9, 0);
        repeat (100) send_byte(8'($urandom), 0);
        #1 Reset_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_loaded", 32'(tex_loaded), 32'h0);
        chk("t6_wr_addr", 32'(wr_addr), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        #1 Reset_n = 1'b1;
        settle(2);
        chk("t6_ready_after", 32'(in_ready), 32'd1);
        w0 = wr_cnt;
        send_byte(8'hA1, 0);
        repeat (3) send_byte(8'($urandom), 0);
        settle(2);
        chk("t6_first_addr", 32'(last_wr_addr), 32'd0);
        chk("t6_one_write", 32'(wr_cnt - w0), 32'd1);
        pulse_abort();
        settle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
